// File: rtl/fifo_r.sv
// fifo_r: AHB read-side word FIFO that unpacks 32-bit HRDATA words into 8-bit pixels, MSB byte first.
// Latency: a word loaded into an empty FIFO appears on pixel_data the next cycle; 1 byte/cycle sustained.
// Backpressure: pixel_ready=0 holds the head byte; fifo_full stalls the master; loads while full are dropped (sticky overflow).
//
// Ports:
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   clear                synchronous flush, overrides every other event
//   load_enable, HRDATA  read data word, valid this cycle
//   pixel_ready          consumer accepts pixel_data this cycle
//   pixel_data/_valid    head byte and its valid flag
//   fifo_full/_empty     word_count == DEPTH / word_count == 0
//   word_count           words held, including a partially consumed head word
//   overflow             sticky, set when a load was dropped
module fifo_r #(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             clear,
   input  logic             load_enable,
   input  logic [31:0]      HRDATA,
   input  logic             pixel_ready,
   output logic [7:0]       pixel_data,
   output logic             pixel_valid,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic [CNT_W-1:0] word_count,
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [1:0]       byte_sel;
   logic [31:0]      head_word;

   logic pop;
   logic last_pop;
   logic accept;
   logic drop;

   assign pixel_valid = (word_count != '0);
   assign fifo_empty  = (word_count == '0);
   assign fifo_full   = (word_count == CNT_W'(DEPTH));

   assign pop      = pixel_valid & pixel_ready;
   assign last_pop = pop & (byte_sel == 2'd3);
   // A full FIFO can still take a word in the cycle its head word retires.
   assign accept   = load_enable & ((word_count < CNT_W'(DEPTH)) | last_pop);
   assign drop     = load_enable & ~accept;

   assign head_word = mem[rd_ptr];

   always_comb begin
      pixel_data = 8'h00;
      if (pixel_valid) begin
         case (byte_sel)
            2'd0:    pixel_data = head_word[31:24];
            2'd1:    pixel_data = head_word[23:16];
            2'd2:    pixel_data = head_word[15:8];
            default: pixel_data = head_word[7:0];
         endcase
      end
   end

   // Storage is deliberately left unreset; pixel_data is masked while empty.
   always_ff @(posedge HCLK) begin
      if (accept && !clear) begin
         mem[wr_ptr] <= HRDATA;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         byte_sel   <= 2'd0;
         word_count <= '0;
         overflow   <= 1'b0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         byte_sel   <= 2'd0;
         word_count <= '0;
         overflow   <= 1'b0;
      end else begin
         // byte_sel wraps 3 -> 0 naturally on the last-byte pop.
         if (pop) begin
            byte_sel <= byte_sel + 2'd1;
         end
         // DEPTH is a power of two, so pointers wrap by overflow.
         if (last_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         case ({accept, last_pop})
            2'b10:   word_count <= word_count + CNT_W'(1);
            2'b01:   word_count <= word_count - CNT_W'(1);
            default: word_count <= word_count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_r.sv
// tb_fifo_r: directed table-driven bench for fifo_r plus hand sequences for
// random backpressure, clear and asynchronous reset.
// Inputs change on the falling edge; outputs are sampled 1 ns later, so each
// table record's expected outputs describe the state before the next rising edge.
module tb_fifo_r;

   logic        HCLK;
   logic        HRESETn;
   logic        clear;
   logic        load_enable;
   logic [31:0] HRDATA;
   logic        pixel_ready;
   logic [7:0]  pixel_data;
   logic        pixel_valid;
   logic        fifo_full;
   logic        fifo_empty;
   logic [2:0]  word_count;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   fifo_r #(.DEPTH(4)) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .clear       (clear),
      .load_enable (load_enable),
      .HRDATA      (HRDATA),
      .pixel_ready (pixel_ready),
      .pixel_data  (pixel_data),
      .pixel_valid (pixel_valid),
      .fifo_full   (fifo_full),
      .fifo_empty  (fifo_empty),
      .word_count  (word_count),
      .overflow    (overflow)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        ld;
      logic [31:0] dat;
      logic        rdy;
      logic        clr;
      logic        e_vld;
      logic [7:0]  e_dat;
      int          e_cnt;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic ld, input logic [31:0] dat, input logic rdy,
                               input logic clr, input logic e_vld, input logic [7:0] e_dat,
                               input int e_cnt, input logic e_ovf);
      vec_t v;
      v.ld = ld; v.dat = dat; v.rdy = rdy; v.clr = clr;
      v.e_vld = e_vld; v.e_dat = e_dat; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic l, input logic [31:0] d, input logic r, input logic c);
      @(negedge HCLK);
      load_enable = l;
      HRDATA      = d;
      pixel_ready = r;
      clear       = c;
      #1;
   endtask

   task automatic chk_state(input string name, input logic e_vld, input logic [7:0] e_dat,
                            input int e_cnt, input logic e_ovf);
      chk({name, "_valid"}, 32'(pixel_valid), 32'(e_vld));
      chk({name, "_data"},  32'(pixel_data),  32'(e_dat));
      chk({name, "_count"}, 32'(word_count),  32'(e_cnt));
      chk({name, "_full"},  32'(fifo_full),   32'(e_cnt == 4));
      chk({name, "_empty"}, 32'(fifo_empty),  32'(e_cnt == 0));
      chk({name, "_ovf"},   32'(overflow),    32'(e_ovf));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic [31:0] wa [4];
      logic [7:0]  exp_q [$];
      int          words_loaded;
      int          model_cnt;
      logic        ld_now;
      logic        rdy_now;

      HRESETn = 1'b0; clear = 1'b0; load_enable = 1'b0; HRDATA = '0; pixel_ready = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      chk_state("reset", 1'b0, 8'h00, 0, 1'b0);
      @(negedge HCLK);
      HRESETn = 1'b1;

      // Single word, free-flowing consumer.
      add(1, 32'hAABBCCDD, 1, 0, 0, 8'h00, 0, 0);
      add(0, 0, 1, 0, 1, 8'hAA, 1, 0);
      add(0, 0, 1, 0, 1, 8'hBB, 1, 0);
      add(0, 0, 1, 0, 1, 8'hCC, 1, 0);
      add(0, 0, 1, 0, 1, 8'hDD, 1, 0);
      add(0, 0, 0, 0, 0, 8'h00, 0, 0);

      // Fill to full, drop a fifth word, drain 16 bytes in order.
      wa[0] = 32'h01020304; wa[1] = 32'h05060708; wa[2] = 32'h090A0B0C; wa[3] = 32'h0D0E0F10;
      add(1, wa[0], 0, 0, 0, 8'h00, 0, 0);
      add(1, wa[1], 0, 0, 1, 8'h01, 1, 0);
      add(1, wa[2], 0, 0, 1, 8'h01, 2, 0);
      add(1, wa[3], 0, 0, 1, 8'h01, 3, 0);
      add(1, 32'hDEADBEEF, 0, 0, 1, 8'h01, 4, 0);
      add(0, 0, 0, 0, 1, 8'h01, 4, 1);
      for (int i = 0; i < 16; i++) begin
         w = wa[i / 4];
         add(0, 0, 1, 0, 1, w[31 - 8 * (i % 4) -: 8], 4 - i / 4, 1);
      end
      add(0, 0, 0, 0, 0, 8'h00, 0, 1);

      // Clear the sticky overflow, then load into a full FIFO on its last-byte pop.
      add(0, 0, 0, 1, 0, 8'h00, 0, 1);
      wa[0] = 32'hA0A1A2A3; wa[1] = 32'hB0B1B2B3; wa[2] = 32'hC0C1C2C3; wa[3] = 32'hD0D1D2D3;
      add(1, wa[0], 0, 0, 0, 8'h00, 0, 0);
      add(1, wa[1], 0, 0, 1, 8'hA0, 1, 0);
      add(1, wa[2], 0, 0, 1, 8'hA0, 2, 0);
      add(1, wa[3], 0, 0, 1, 8'hA0, 3, 0);
      add(0, 0, 1, 0, 1, 8'hA0, 4, 0);
      add(0, 0, 1, 0, 1, 8'hA1, 4, 0);
      add(0, 0, 1, 0, 1, 8'hA2, 4, 0);
      add(1, 32'h11223344, 1, 0, 1, 8'hA3, 4, 0);
      add(0, 0, 0, 0, 1, 8'hB0, 4, 0);
      wa[0] = 32'hB0B1B2B3; wa[1] = 32'hC0C1C2C3; wa[2] = 32'hD0D1D2D3; wa[3] = 32'h11223344;
      for (int i = 0; i < 16; i++) begin
         w = wa[i / 4];
         add(0, 0, 1, 0, 1, w[31 - 8 * (i % 4) -: 8], 4 - i / 4, 0);
      end
      add(0, 0, 0, 0, 0, 8'h00, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ld, vecs[i].dat, vecs[i].rdy, vecs[i].clr);
         chk_state($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_dat, vecs[i].e_cnt, vecs[i].e_ovf);
      end

      // Random backpressure over 8 words against a byte scoreboard.
      words_loaded = 0;
      for (int cyc = 0; cyc < 400 && (words_loaded < 8 || exp_q.size() != 0); cyc++) begin
         model_cnt = (exp_q.size() + 3) / 4;
         rdy_now   = 1'($urandom_range(0, 1));
         ld_now    = (words_loaded < 8) && (model_cnt < 4);
         w         = 32'h10203040 + 32'(words_loaded) * 32'h01010101;
         drive(ld_now, w, rdy_now, 1'b0);
         chk("rand_count", 32'(word_count), 32'(model_cnt));
         chk("rand_valid", 32'(pixel_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("rand_data", 32'(pixel_data), 32'(exp_q[0]));
            if (rdy_now) void'(exp_q.pop_front());
         end
         if (ld_now) begin
            exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
            words_loaded++;
         end
      end
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      chk("rand_loaded", 32'(words_loaded), 32'd8);

      // Clear mid-word with a concurrent load and pop.
      drive(0, 0, 0, 0);
      drive(1, 32'h55667788, 0, 0);
      drive(1, 32'h99AABBCC, 0, 0);
      drive(1, 32'h01010101, 0, 0);
      drive(1, 32'h02020202, 0, 0);
      drive(1, 32'h03030303, 0, 0);
      drive(0, 0, 1, 0);
      chk_state("pre_clr_a", 1'b1, 8'h55, 4, 1'b1);
      drive(0, 0, 1, 0);
      chk_state("pre_clr_b", 1'b1, 8'h66, 4, 1'b1);
      drive(1, 32'hEEEEEEEE, 1, 1);
      chk_state("at_clr", 1'b1, 8'h77, 4, 1'b1);
      drive(1, 32'h12345678, 0, 0);
      chk_state("post_clr", 1'b0, 8'h00, 0, 1'b0);
      drive(0, 0, 0, 0);
      chk_state("clr_reload", 1'b1, 8'h12, 1, 1'b0);
      repeat (4) drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
      chk_state("clr_drained", 1'b0, 8'h00, 0, 1'b0);

      // Asynchronous reset mid-word.
      drive(1, 32'hCAFEF00D, 0, 0);
      drive(0, 0, 1, 0);
      chk("ar_byte0", 32'(pixel_data), 32'hCA);
      drive(0, 0, 0, 0);
      chk("ar_byte1", 32'(pixel_data), 32'hFE);
      @(posedge HCLK);
      #2;
      HRESETn = 1'b0;
      #1;
      chk_state("async_rst", 1'b0, 8'h00, 0, 1'b0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      drive(1, 32'h01234567, 0, 0);
      chk_state("ar_empty", 1'b0, 8'h00, 0, 1'b0);
      drive(0, 0, 1, 0);
      chk_state("ar_resume0", 1'b1, 8'h01, 1, 1'b0);
      drive(0, 0, 0, 0);
      chk_state("ar_resume1", 1'b1, 8'h23, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
